// File: rtl/mem_router_pkg.sv
// Shared definitions for the memory region router.
// Holds the FSM state encoding, the default five-region address map and the
// helper that sizes region-index fields.
package mem_router_pkg;

    localparam int unsigned DEF_NUM_REGIONS = 5;
    localparam int unsigned DEF_ADDR_W      = 32;

    // Router FSM state encoding
    typedef logic [1:0] router_state_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Default map; region i lives in slice i (rightmost entry is region 0):
    // RAM 0x0000, ROM 0x0800, IO 0x1800, HD 0x2B00, TIMER 0x6B00
    localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE = {
        32'h0000_6B00, 32'h0000_2B00, 32'h0000_1800, 32'h0000_0800, 32'h0000_0000
    };
    localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_SIZE = {
        32'h0000_0100, 32'h0000_4000, 32'h0000_1300, 32'h0000_1000, 32'h0000_0800
    };

    // Width of a region index; never narrower than one bit
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder.
// Finds the lowest-index region containing addr and the region-relative offset.
// Ports:
//   addr   in  ADDR_W   global address
//   hit    out 1        addr falls inside some region
//   index  out IDX_W    lowest matching region index (0 on miss)
//   offset out ADDR_W   addr - base of matching region (0 on miss)
module mem_region_decode
    import mem_router_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE
) (
    input  logic [ADDR_W-1:0]                      addr,
    output logic                                   hit,
    output logic [idxWidth(NUM_REGIONS)-1:0]       index,
    output logic [ADDR_W-1:0]                      offset
);

    localparam int unsigned IDX_W = idxWidth(NUM_REGIONS);

    logic [ADDR_W:0] addrExt;
    logic [ADDR_W:0] baseExt;
    logic [ADDR_W:0] endExt;

    // Scan from the top down so the lowest matching index wins; the extra
    // bit keeps base+size from wrapping at the top of the address space.
    always_comb begin
        hit     = 1'b0;
        index   = '0;
        offset  = '0;
        addrExt = {1'b0, addr};
        baseExt = '0;
        endExt  = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            baseExt = {1'b0, REGION_BASE[i*ADDR_W +: ADDR_W]};
            endExt  = baseExt + {1'b0, REGION_SIZE[i*ADDR_W +: ADDR_W]};
            if ((addrExt >= baseExt) && (addrExt < endExt)) begin
                hit    = 1'b1;
                index  = IDX_W'(i);
                offset = addr - REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/mem_region_router.sv
// Single-master to multi-slave memory region router.
// Accepts one request at a time, decodes it to a region, drives the selected
// slave until it acks or the wait budget runs out, then returns a one-cycle
// response.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only when idle)
//   req_write, req_addr, req_wdata   request payload
//   rsp_valid                        one-cycle completion pulse
//   rsp_rdata, rsp_err, rsp_region   response payload, held until next response
//   s_sel, s_we, s_addr, s_wdata     slave-side request (one-hot select)
//   s_rdata, s_ack                   per-slave read data and completion
module mem_region_router
    import mem_router_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_write,
    input  logic [ADDR_W-1:0]                   req_addr,
    input  logic [DATA_W-1:0]                   req_wdata,
    output logic                                rsp_valid,
    output logic [DATA_W-1:0]                   rsp_rdata,
    output logic                                rsp_err,
    output logic [idxWidth(NUM_REGIONS)-1:0]    rsp_region,
    output logic [NUM_REGIONS-1:0]              s_sel,
    output logic                                s_we,
    output logic [ADDR_W-1:0]                   s_addr,
    output logic [DATA_W-1:0]                   s_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0]       s_rdata,
    input  logic [NUM_REGIONS-1:0]              s_ack
);

    localparam int unsigned IDX_W = idxWidth(NUM_REGIONS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    router_state_t      stateQ;
    router_state_t      stateNext;
    logic [CNT_W-1:0]   waitCnt;
    logic [IDX_W-1:0]   selIdx;

    logic               decHit;
    logic [IDX_W-1:0]   decIdx;
    logic [ADDR_W-1:0]  decOff;

    logic               accept;
    logic               ackHit;
    logic               timeoutHit;

    mem_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .addr   (req_addr),
        .hit    (decHit),
        .index  (decIdx),
        .offset (decOff)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next-state logic; acks only count for the selected slave while in ACCESS
    always_comb begin
        stateNext  = stateQ;
        accept     = 1'b0;
        ackHit     = 1'b0;
        timeoutHit = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    stateNext = decHit ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                ackHit     = |(s_ack & s_sel);
                timeoutHit = (waitCnt == CNT_W'(TIMEOUT - 1));
                if (ackHit || timeoutHit) begin
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and datapath; ack takes priority over timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            rsp_region <= '0;
            s_sel      <= '0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            selIdx     <= '0;
            waitCnt    <= '0;
        end else begin
            req_ready <= (stateNext == ST_IDLE);
            rsp_valid <= (stateNext == ST_RESP);

            if (accept) begin
                s_wdata <= req_wdata;
                selIdx  <= decIdx;
                waitCnt <= '0;
                if (decHit) begin
                    s_sel  <= NUM_REGIONS'(1) << decIdx;
                    s_we   <= req_write;
                    s_addr <= decOff;
                end else begin
                    s_addr     <= '0;
                    rsp_err    <= 1'b1;
                    rsp_rdata  <= '0;
                    rsp_region <= '0;
                end
            end

            if (stateQ == ST_ACCESS) begin
                if (ackHit) begin
                    rsp_err    <= 1'b0;
                    rsp_rdata  <= s_we ? '0 : s_rdata[selIdx*DATA_W +: DATA_W];
                    rsp_region <= selIdx;
                    s_sel      <= '0;
                    s_we       <= 1'b0;
                end else if (timeoutHit) begin
                    rsp_err    <= 1'b1;
                    rsp_rdata  <= '0;
                    rsp_region <= selIdx;
                    s_sel      <= '0;
                    s_we       <= 1'b0;
                end else begin
                    waitCnt <= waitCnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_region_router.sv
module tb_mem_region_router;

    localparam int TIMEOUT = 16;
    localparam int LIMIT   = TIMEOUT + 6;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [2:0]   rsp_region;
    logic [4:0]   s_sel;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [159:0] s_rdata;
    logic [4:0]   s_ack;

    int errors = 0;
    int checks = 0;

    mem_region_router #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_region (rsp_region),
        .s_sel      (s_sel),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_ack      (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackAt;     // ACCESS cycle (1-based after accept) of ack; 0 = never
        logic [31:0] ackData;
        bit          spurious;  // pulse s_ack[0] during the wait
        logic [4:0]  expSel;
        logic [31:0] expAddr;
        bit          expWe;
        int          expLat;
        bit          expErr;
        logic [31:0] expRdata;
        int          expRegion;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE and follow it through to the response
    task automatic doTxn(input vec_t v);
        int got;
        got = 0;
        @(posedge clk); #1;
        check({v.name, " ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= LIMIT; c++) begin
            s_ack   = '0;
            s_rdata = '0;
            if (v.ackAt == c) begin
                s_ack[v.expRegion] = 1'b1;
                s_rdata[v.expRegion*32 +: 32] = v.ackData;
            end
            if (v.spurious && c >= 2 && c <= 5) begin
                s_ack[0] = 1'b1;
                s_rdata[31:0] = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            if (c == 1) begin
                check({v.name, " s_sel"}, 64'(s_sel), 64'(v.expSel));
                check({v.name, " s_we"},  64'(s_we),  64'(v.expWe));
                if (v.expSel != 5'd0) begin
                    check({v.name, " s_addr"}, 64'(s_addr), 64'(v.expAddr));
                    if (v.write) check({v.name, " s_wdata"}, 64'(s_wdata), 64'(v.wdata));
                end
            end
            if (rsp_valid) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
        end
        s_ack   = '0;
        s_rdata = '0;
        check({v.name, " latency"},    64'(got),        64'(v.expLat));
        check({v.name, " rsp_err"},    64'(rsp_err),    64'(v.expErr));
        check({v.name, " rsp_rdata"},  64'(rsp_rdata),  64'(v.expRdata));
        check({v.name, " rsp_region"}, 64'(rsp_region), 64'(v.expRegion));
        check({v.name, " sel in RESP"}, 64'(s_sel), 64'd0);
        @(negedge clk);
        check({v.name, " pulse ends"}, 64'(rsp_valid), 64'd0);
        check({v.name, " ready back"}, 64'(req_ready), 64'd1);
        check({v.name, " rdata held"}, 64'(rsp_rdata), 64'(v.expRdata));
        check({v.name, " err held"},   64'(rsp_err),   64'(v.expErr));
    endtask

    initial begin
        vec_t v;
        int   bad;
        logic [0:8] expReady;
        logic [0:8] expValid;

        //         name       wr    addr          wdata         ackAt  ackData       spur  sel       saddr        we  lat  err  rdata         reg
        vecs[0]  = '{"ram_rd",  1'b0, 32'h0000_0010, 32'h0,        1,     32'hDEADBEEF, 1'b0, 5'b00001, 32'h10,      1'b0, 2,  1'b0, 32'hDEADBEEF, 0};
        vecs[1]  = '{"hd_wr",   1'b1, 32'h0000_2B04, 32'h55,       4,     32'h12345678, 1'b0, 5'b01000, 32'h4,       1'b1, 5,  1'b0, 32'h0,        3};
        vecs[2]  = '{"unmap",   1'b0, 32'h0000_7000, 32'h0,        0,     32'h0,        1'b0, 5'b00000, 32'h0,       1'b0, 1,  1'b1, 32'h0,        0};
        vecs[3]  = '{"tmr_to",  1'b0, 32'h0000_6B10, 32'h0,        0,     32'h0,        1'b1, 5'b10000, 32'h10,      1'b0, TIMEOUT+1, 1'b1, 32'h0, 4};
        vecs[4]  = '{"tmr_last",1'b0, 32'h0000_6B20, 32'h0,        TIMEOUT, 32'hCAFE0001, 1'b0, 5'b10000, 32'h20,    1'b0, TIMEOUT+1, 1'b0, 32'hCAFE0001, 4};
        vecs[5]  = '{"rom_lo",  1'b0, 32'h0000_0800, 32'h0,        2,     32'h000000A1, 1'b0, 5'b00010, 32'h0,       1'b0, 3,  1'b0, 32'h000000A1, 1};
        vecs[6]  = '{"rom_hi",  1'b0, 32'h0000_17FF, 32'h0,        1,     32'h000000B2, 1'b0, 5'b00010, 32'hFFF,     1'b0, 2,  1'b0, 32'h000000B2, 1};
        vecs[7]  = '{"io_lo",   1'b0, 32'h0000_1800, 32'h0,        1,     32'h000000C3, 1'b0, 5'b00100, 32'h0,       1'b0, 2,  1'b0, 32'h000000C3, 2};
        vecs[8]  = '{"tmr_hi",  1'b0, 32'h0000_6BFF, 32'h0,        3,     32'h0000D4D4, 1'b0, 5'b10000, 32'hFF,      1'b0, 4,  1'b0, 32'h0000D4D4, 4};
        vecs[9]  = '{"past_end",1'b0, 32'h0000_6C00, 32'h0,        0,     32'h0,        1'b0, 5'b00000, 32'h0,       1'b0, 1,  1'b1, 32'h0,        0};
        vecs[10] = '{"top_addr",1'b0, 32'hFFFF_FFFF, 32'h0,        0,     32'h0,        1'b0, 5'b00000, 32'h0,       1'b0, 1,  1'b1, 32'h0,        0};
        vecs[11] = '{"io_wr",   1'b1, 32'h0000_2AFF, 32'hA5A5A5A5, 1,     32'h77777777, 1'b0, 5'b00100, 32'h12FF,    1'b1, 2,  1'b0, 32'h0,        2};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        s_rdata   = '0;
        s_ack     = '0;

        // Reset state
        #1;
        check("rst s_sel",      64'(s_sel),      64'd0);
        check("rst rsp_valid",  64'(rsp_valid),  64'd0);
        check("rst rsp_rdata",  64'(rsp_rdata),  64'd0);
        check("rst rsp_err",    64'(rsp_err),    64'd0);
        check("rst s_addr",     64'(s_addr),     64'd0);
        check("rst s_we",       64'(s_we),       64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst ready", 64'(req_ready), 64'd1);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            doTxn(vecs[i]);
        end

        // Back-to-back: req_valid held, slave 0 acks continuously (also outside ACCESS)
        expReady = 9'b100100100;
        expValid = 9'b001001001;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0020;
        s_ack     = 5'b00001;
        s_rdata   = '0;
        s_rdata[31:0] = 32'h0BAD_F00D;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("b2b ready c%0d", c), 64'(req_ready), 64'(expReady[c]));
            check($sformatf("b2b valid c%0d", c), 64'(rsp_valid), 64'(expValid[c]));
            @(posedge clk); #1;
            if (c == 8) req_valid = 1'b0;
        end
        s_ack   = '0;
        s_rdata = '0;
        @(negedge clk);
        check("b2b rdata", 64'(rsp_rdata), 64'h0BAD_F00D);

        // Reset in the middle of an access
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid sel before rst", 64'(s_sel), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst s_sel",     64'(s_sel),     64'd0);
        check("mid rst rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("mid rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid rst s_addr",    64'(s_addr),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("no pulse after rst", 64'(bad), 64'd0);
        v = vecs[0];
        v.name = "after_rst";
        doTxn(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Whole-run guard
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
